// File: rtl/keypad_pkg.sv
// Shared types, constants and small decode helpers for the 4x3 keypad scanner.
package keypad_pkg;

    localparam int ROW_W     = 4;
    localparam int COL_W     = 3;
    localparam int COL_IDX_W = 2;
    localparam int KEY_W     = 4;

    localparam logic [KEY_W-1:0] KEY_STAR = 4'hA;
    localparam logic [KEY_W-1:0] KEY_HASH = 4'hB;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_PRESS_DB,
        ST_HOLD,
        ST_RELEASE_DB
    } state_t;

    typedef logic [COL_IDX_W-1:0] col_idx_t;

    // True when exactly one of the active-low rows is pulled down.
    function automatic logic one_row_low(input logic [ROW_W-1:0] rows);
        return $onehot(~rows);
    endfunction

    function automatic logic [1:0] row_index(input logic [ROW_W-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < ROW_W; i++) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [COL_W-1:0] col_drive(input col_idx_t idx);
        return ~(COL_W'(1) << idx);
    endfunction

    function automatic col_idx_t next_col(input col_idx_t idx);
        return (idx == col_idx_t'(COL_W - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Rows 0-2 hold digits 1-9 in reading order; row 3 is *, 0, #.
    function automatic logic [KEY_W-1:0] key_code(input logic [1:0] row, input col_idx_t col);
        logic [KEY_W-1:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module keypad_sync #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column scan, press/release debounce and key decode.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROW_W-1:0] row_in,
    output logic [COL_W-1:0] col_out,
    output logic [KEY_W-1:0] data,
    output logic             is_pressed,
    output logic             is_star_pressed,
    output logic             is_hash_pressed,
    output logic             key_held
);

    localparam int CNT_SPAN = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W    = $clog2(CNT_SPAN) + 1;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    logic [ROW_W-1:0] rows_sync;
    state_t           state_reg;
    col_idx_t         col_idx_reg;
    col_idx_t         col_d1_reg;
    col_idx_t         col_d2_reg;
    logic [ROW_W-1:0] sample_reg;
    logic [CNT_W-1:0] scan_cnt_reg;
    logic [CNT_W-1:0] db_cnt_reg;
    logic [COL_W-1:0] col_out_reg;
    logic [KEY_W-1:0] data_reg;
    logic             is_pressed_reg;
    logic             is_star_reg;
    logic             is_hash_reg;
    logic             key_held_reg;
    logic             settled;
    logic [KEY_W-1:0] key_now;

    keypad_sync #(
        .WIDTH     (ROW_W),
        .RESET_VAL ({ROW_W{1'b1}})
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_in),
        .q     (rows_sync)
    );

    // rows_sync lags the column drive by the synchronizer depth, so col_d2_reg
    // names the column whose response is currently visible. Row samples are
    // only trusted once that column matches the one being driven.
    assign settled = (col_d2_reg == col_idx_reg);
    assign key_now = key_code(row_index(sample_reg), col_idx_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_SCAN;
            col_idx_reg    <= '0;
            col_d1_reg     <= '0;
            col_d2_reg     <= '0;
            sample_reg     <= '1;
            scan_cnt_reg   <= '0;
            db_cnt_reg     <= '0;
            col_out_reg    <= 3'b110;
            data_reg       <= '0;
            is_pressed_reg <= 1'b0;
            is_star_reg    <= 1'b0;
            is_hash_reg    <= 1'b0;
            key_held_reg   <= 1'b0;
        end else begin
            col_d1_reg     <= col_idx_reg;
            col_d2_reg     <= col_d1_reg;
            is_pressed_reg <= 1'b0;
            is_star_reg    <= 1'b0;
            is_hash_reg    <= 1'b0;

            case (state_reg)
                ST_SCAN: begin
                    db_cnt_reg <= '0;
                    if (one_row_low(rows_sync)) begin
                        // Snap back to the column that actually produced this sample.
                        state_reg    <= ST_PRESS_DB;
                        sample_reg   <= rows_sync;
                        col_idx_reg  <= col_d2_reg;
                        col_out_reg  <= col_drive(col_d2_reg);
                        scan_cnt_reg <= '0;
                    end else if (scan_cnt_reg >= SCAN_LAST) begin
                        col_idx_reg  <= next_col(col_idx_reg);
                        col_out_reg  <= col_drive(next_col(col_idx_reg));
                        scan_cnt_reg <= '0;
                    end else if (scan_cnt_reg != CNT_SAT) begin
                        scan_cnt_reg <= scan_cnt_reg + 1'b1;
                    end
                end

                ST_PRESS_DB: begin
                    if (settled) begin
                        if (rows_sync != sample_reg) begin
                            state_reg    <= ST_SCAN;
                            db_cnt_reg   <= '0;
                            scan_cnt_reg <= '0;
                        end else if (db_cnt_reg >= DB_LAST) begin
                            if (key_now == KEY_STAR) begin
                                is_star_reg <= 1'b1;
                            end else if (key_now == KEY_HASH) begin
                                is_hash_reg <= 1'b1;
                            end else begin
                                is_pressed_reg <= 1'b1;
                                data_reg       <= key_now;
                            end
                            key_held_reg <= 1'b1;
                            db_cnt_reg   <= '0;
                            state_reg    <= ST_HOLD;
                        end else if (db_cnt_reg != CNT_SAT) begin
                            db_cnt_reg <= db_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_HOLD: begin
                    if (settled && rows_sync == {ROW_W{1'b1}}) begin
                        state_reg  <= ST_RELEASE_DB;
                        db_cnt_reg <= '0;
                    end
                end

                ST_RELEASE_DB: begin
                    if (settled) begin
                        if (rows_sync != {ROW_W{1'b1}}) begin
                            state_reg  <= ST_HOLD;
                            db_cnt_reg <= '0;
                        end else if (db_cnt_reg >= DB_LAST) begin
                            key_held_reg <= 1'b0;
                            db_cnt_reg   <= '0;
                            scan_cnt_reg <= '0;
                            col_idx_reg  <= next_col(col_idx_reg);
                            col_out_reg  <= col_drive(next_col(col_idx_reg));
                            state_reg    <= ST_SCAN;
                        end else if (db_cnt_reg != CNT_SAT) begin
                            db_cnt_reg <= db_cnt_reg + 1'b1;
                        end
                    end
                end

                default: state_reg <= ST_SCAN;
            endcase
        end
    end

    assign col_out         = col_out_reg;
    assign data            = data_reg;
    assign is_pressed      = is_pressed_reg;
    assign is_star_pressed = is_star_reg;
    assign is_hash_pressed = is_hash_reg;
    assign key_held        = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix model.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_in;
    logic [2:0] col_out;
    logic [3:0] data;
    logic       is_pressed;
    logic       is_star_pressed;
    logic       is_hash_pressed;
    logic       key_held;

    // Keypad model: each "key" pulls its row mask low while its column is driven.
    logic       key_down = 1'b0;
    logic [3:0] key_mask = 4'b0000;
    logic [1:0] key_col = 2'd0;
    logic       key2_down = 1'b0;
    logic [3:0] key2_mask = 4'b0000;
    logic [1:0] key2_col = 2'd0;

    int n_checks = 0;
    int n_fail = 0;
    int n_pressed = 0;
    int n_star = 0;
    int n_hash = 0;
    int n_multi = 0;
    int n_badcol = 0;
    logic [3:0] strobe_data = 4'h0;

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        logic [3:0] exp_data;
        int         exp_digit;
        int         exp_star;
        int         exp_hash;
    } vec_t;

    vec_t vecs[8];

    keypad_scanner #(
        .SCAN_CYCLES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .row_in          (row_in),
        .col_out         (col_out),
        .data            (data),
        .is_pressed      (is_pressed),
        .is_star_pressed (is_star_pressed),
        .is_hash_pressed (is_hash_pressed),
        .key_held        (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        if (key_down && col_out == ~(3'b001 << key_col)) row_in = row_in & ~key_mask;
        if (key2_down && col_out == ~(3'b001 << key2_col)) row_in = row_in & ~key2_mask;
    end

    always @(negedge clk) begin
        if (is_pressed) begin
            n_pressed++;
            strobe_data = data;
        end
        if (is_star_pressed) n_star++;
        if (is_hash_pressed) n_hash++;
        if ((int'(is_pressed) + int'(is_star_pressed) + int'(is_hash_pressed)) > 1) n_multi++;
        if (col_out != 3'b110 && col_out != 3'b101 && col_out != 3'b011) n_badcol++;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_held(input logic target, input int budget, input string name);
        for (int i = 0; i < budget && key_held !== target; i++) @(negedge clk);
        n_checks++;
        if (key_held !== target) begin
            n_fail++;
            $display("FAIL %s: key_held=%0b, expected %0b within %0d clks", name, key_held, target, budget);
        end
    endtask

    task automatic wait_col(input logic [2:0] pattern, input int budget, input string name);
        for (int i = 0; i < budget && col_out !== pattern; i++) @(negedge clk);
        n_checks++;
        if (col_out !== pattern) begin
            n_fail++;
            $display("FAIL %s: col_out=%b, expected %b within %0d clks", name, col_out, pattern, budget);
        end
    endtask

    initial begin
        logic [2:0] exp_cols[8];
        int p0, s0, h0, trans;
        logic [2:0] prev_col;

        vecs[0] = '{2'd1, 2'd1, 4'h5, 1, 0, 0};
        vecs[1] = '{2'd3, 2'd0, 4'h5, 0, 1, 0};
        vecs[2] = '{2'd3, 2'd2, 4'h5, 0, 0, 1};
        vecs[3] = '{2'd0, 2'd0, 4'h1, 1, 0, 0};
        vecs[4] = '{2'd2, 2'd2, 4'h9, 1, 0, 0};
        vecs[5] = '{2'd3, 2'd1, 4'h0, 1, 0, 0};
        vecs[6] = '{2'd0, 2'd2, 4'h3, 1, 0, 0};
        vecs[7] = '{2'd2, 2'd0, 4'h7, 1, 0, 0};
        exp_cols = '{3'b110, 3'b101, 3'b101, 3'b011, 3'b011, 3'b110, 3'b110, 3'b101};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col_out", int'(col_out), 3'b110);
        check("rst_data", int'(data), 0);
        check("rst_key_held", int'(key_held), 0);
        check("rst_strobes", int'(is_pressed) + int'(is_star_pressed) + int'(is_hash_pressed), 0);
        reset = 1'b0;

        // Idle scan sequence, two clocks per column
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("idle_col[%0d]", i), int'(col_out), int'(exp_cols[i]));
        end
        check("idle_no_strobes", n_pressed + n_star + n_hash, 0);
        $display("idle scan: col_out sequence checked over 8 clks");

        // Table-driven key presses
        for (int v = 0; v < 8; v++) begin
            p0 = n_pressed; s0 = n_star; h0 = n_hash;
            key_mask = 4'b0001 << vecs[v].row;
            key_col  = vecs[v].col;
            key_down = 1'b1;
            wait_held(1'b1, 100, $sformatf("v%0d_held_on", v));
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_held_long", v), int'(key_held), 1);
            key_down = 1'b0;
            repeat (5) @(negedge clk);
            check($sformatf("v%0d_held_release_db", v), int'(key_held), 1);
            wait_held(1'b0, 100, $sformatf("v%0d_held_off", v));
            check($sformatf("v%0d_pressed_cnt", v), n_pressed - p0, vecs[v].exp_digit);
            check($sformatf("v%0d_star_cnt", v), n_star - s0, vecs[v].exp_star);
            check($sformatf("v%0d_hash_cnt", v), n_hash - h0, vecs[v].exp_hash);
            check($sformatf("v%0d_data", v), int'(data), int'(vecs[v].exp_data));
            if (vecs[v].exp_digit != 0)
                check($sformatf("v%0d_data_at_strobe", v), int'(strobe_data), int'(vecs[v].exp_data));
            $display("key r%0d c%0d: data=%h pressed=%0d star=%0d hash=%0d",
                     vecs[v].row, vecs[v].col, data, n_pressed - p0, n_star - s0, n_hash - h0);
        end

        // Bounce on key 8: low 2 clks, high 1, then low and stable
        p0 = n_pressed;
        key_mask = 4'b0100; key_col = 2'd1;
        wait_col(3'b101, 20, "bounce_wait_col1");
        key_down = 1'b1; repeat (2) @(negedge clk);
        key_down = 1'b0; @(negedge clk);
        key_down = 1'b1;
        wait_held(1'b1, 100, "bounce_held_on");
        repeat (10) @(negedge clk);
        key_down = 1'b0;
        wait_held(1'b0, 100, "bounce_held_off");
        check("bounce_pressed_cnt", n_pressed - p0, 1);
        check("bounce_data", int'(data), 4'h8);
        $display("bounce key 8: data=%h pressed=%0d", data, n_pressed - p0);

        // Second key in another column while holding key 1
        p0 = n_pressed; s0 = n_star; h0 = n_hash;
        key_mask = 4'b0001; key_col = 2'd0; key_down = 1'b1;
        wait_held(1'b1, 100, "dual_held_on");
        key2_mask = 4'b0010; key2_col = 2'd2; key2_down = 1'b1;
        repeat (30) @(negedge clk);
        key2_down = 1'b0;
        repeat (5) @(negedge clk);
        key_down = 1'b0;
        wait_held(1'b0, 100, "dual_held_off");
        check("dual_pressed_cnt", n_pressed - p0, 1);
        check("dual_other_cnt", (n_star - s0) + (n_hash - h0), 0);
        check("dual_data", int'(data), 4'h1);
        $display("dual key 1 + 6: data=%h pressed=%0d", data, n_pressed - p0);

        // Two rows low on col0: no key, scanning continues
        p0 = n_pressed; s0 = n_star; h0 = n_hash;
        key_mask = 4'b0011; key_col = 2'd0; key_down = 1'b1;
        trans = 0; prev_col = col_out;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col_out != prev_col) trans++;
            prev_col = col_out;
        end
        key_down = 1'b0;
        check("multi_no_strobe", (n_pressed - p0) + (n_star - s0) + (n_hash - h0), 0);
        check("multi_key_held", int'(key_held), 0);
        check("multi_scanning", int'(trans >= 10), 1);
        check("multi_data_kept", int'(data), 4'h1);
        $display("rows 1100 on col0: column transitions=%0d strobes=%0d", trans, n_pressed - p0);

        // Reset during debounce of key 9
        p0 = n_pressed; s0 = n_star; h0 = n_hash;
        key_mask = 4'b0100; key_col = 2'd2;
        wait_col(3'b011, 20, "rst_pdb_wait_col2");
        key_down = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        key_down = 1'b0;
        check("rst_pdb_col_out", int'(col_out), 3'b110);
        check("rst_pdb_data", int'(data), 0);
        check("rst_pdb_key_held", int'(key_held), 0);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("rst_pdb_no_strobe", (n_pressed - p0) + (n_star - s0) + (n_hash - h0), 0);
        check("rst_pdb_data_after", int'(data), 0);
        check("rst_pdb_held_after", int'(key_held), 0);
        $display("reset during debounce of 9: data=%h strobes=%0d", data, n_pressed - p0);

        check("one_strobe_at_a_time", n_multi, 0);
        check("col_one_hot_low", n_badcol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 1000, meaning clock cycles each column is driven before advancing.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20000, meaning consecutive identical samples required for press or release acceptance.
REQ-003 SHALL have port clk  input  1  rising-edge system clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port row_in  input  4  keypad rows, active-low, pulled up externally, asynchronous to clk.
REQ-006 SHALL have port col_out  output  3  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port data  output  4  8421 BCD code of the last accepted digit key.
REQ-008 SHALL have port is_pressed  output  1  one-cycle strobe on acceptance of a digit key 0-9.
REQ-009 SHALL have port is_star_pressed  output  1  one-cycle strobe on acceptance of the * key.
REQ-010 SHALL have port is_hash_pressed  output  1  one-cycle strobe on acceptance of the # key.
REQ-011 SHALL have port key_held  output  1  high from acceptance until release is accepted.

Function
REQ-012 SHALL pass row_in through a 2-flop synchronizer; all logic uses synchronized rows only.
REQ-013 SHALL map keys (row,col): r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = *,0,#; col0 leftmost.
REQ-014 SHALL implement states SCAN, PRESS_DB, HOLD, RELEASE_DB.
REQ-015 SCAN: drive col k low for SCAN_CYCLES cycles, then advance k = 0->1->2->0; on exactly one synchronized row low, freeze column, load sample, go PRESS_DB.
REQ-016 PRESS_DB: column frozen; counter increments per cycle while synchronized rows equal the loaded sample; any change returns to SCAN at the same column with counter cleared.
REQ-017 PRESS_DB: on DEBOUNCE_CYCLES consecutive matches, assert exactly one strobe for one cycle in the next cycle, set key_held, go HOLD.
REQ-018 Digit acceptance SHALL update data in the same cycle its is_pressed strobe is high; * and # SHALL leave data unchanged.
REQ-019 HOLD: column frozen; no strobes; on rows 4'b1111 go RELEASE_DB.
REQ-020 RELEASE_DB: DEBOUNCE_CYCLES consecutive 4'b1111 samples clear key_held and return to SCAN at next column; any row low returns to HOLD.
REQ-021 Two or more rows low in SCAN or PRESS_DB SHALL be treated as no key: SCAN keeps scanning; PRESS_DB returns to SCAN.
REQ-022 A second key in a different column while holding SHALL be ignored; no auto-repeat.
REQ-023 At most one of is_pressed, is_star_pressed, is_hash_pressed SHALL be high in any cycle.
REQ-024 Counters SHALL be sized $clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES))+1 bits and SHALL saturate, never wrap.

Reset
REQ-025 Reset SHALL force state SCAN, col_out 3'b110, data 4'b0000, all strobes 0, key_held 0, counters 0, synchronizer flops 4'b1111.
REQ-026 Reset mid-PRESS_DB or mid-HOLD SHALL discard the pending key with no strobe after release of reset.
REQ-027 The first press after reset release SHALL be accepted only after full debounce.

Structure
REQ-028 Shared package SHALL hold state enum, key-code constants (KEY_STAR, KEY_HASH), row/column widths.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module keypad_sync (parameterized width, reset value).

Verification (bench: SCAN_CYCLES=2, DEBOUNCE_CYCLES=4)
REQ-030 Reset, idle rows 4'b1111 -> col_out cycles 110,101,011 every 2 clks; no strobes.
REQ-031 Hold row1 low while col1 driven -> one is_pressed, data=4'b0101, key_held=1 until release + 4 clean cycles.
REQ-032 row3 low on col0 -> one is_star_pressed; data keeps prior value 0101; row3 col2 -> one is_hash_pressed.
REQ-033 Bounce: row2 low 2 clks, high 1, low stable on col1 -> single is_pressed, data=4'b1000, never two strobes.
REQ-034 Rows 4'b1100 on col0 -> no strobe, scanning continues.
REQ-035 Assert reset during PRESS_DB of key 9 -> no strobe, data=0000, col_out=110 after reset.
